// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: multi-cycle fetch/PC stage that holds the PC, fetches one instruction and computes the next PC from ALU results
// Ports:
//   clk_i, reset_i                  clock and synchronous active-high reset
//   imem_req_o/addr_o/ready_i/rdata_i  instruction memory fetch handshake
//   instr_o, instr_pc_o, instr_valid_o  latched instruction for decode/ALU
//   ex_done_i, pc_select_i, branch_offset_i, jal_i, jalr_i, jalr_target_i, halt_req_i  execute results
//   link_addr_o                     instr_pc + 4 for JAL/JALR rd write
//   instret_o, halted_o, misaligned_o  status
module fetch_pc_unit #(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   output logic                  imem_req_o,
   output logic [DATA_WIDTH-1:0] imem_addr_o,
   input  logic                  imem_ready_i,
   input  logic [DATA_WIDTH-1:0] imem_rdata_i,
   output logic [DATA_WIDTH-1:0] instr_o,
   output logic [DATA_WIDTH-1:0] instr_pc_o,
   output logic                  instr_valid_o,
   input  logic                  ex_done_i,
   input  logic                  pc_select_i,
   input  logic [DATA_WIDTH-1:0] branch_offset_i,
   input  logic                  jal_i,
   input  logic                  jalr_i,
   input  logic [DATA_WIDTH-1:0] jalr_target_i,
   input  logic                  halt_req_i,
   output logic [DATA_WIDTH-1:0] link_addr_o,
   output logic [DATA_WIDTH-1:0] instret_o,
   output logic                  halted_o,
   output logic                  misaligned_o
);
   typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;
   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] pc_q, pc_d, instr_q, instr_d, instr_pc_q, instr_pc_d;
   logic [DATA_WIDTH-1:0] instret_q, instret_d, next_pc;
   logic                  misaligned_q, misaligned_d;
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= S_FETCH;
         pc_q         <= RESET_PC;
         instr_q      <= '0;
         instr_pc_q   <= '0;
         instret_q    <= '0;
         misaligned_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         instr_q      <= instr_d;
         instr_pc_q   <= instr_pc_d;
         instret_q    <= instret_d;
         misaligned_q <= misaligned_d;
      end
   end
   // jalr beats jal beats a taken branch; JALR target has bit 0 cleared
   assign next_pc = jalr_i ? {jalr_target_i[DATA_WIDTH-1:1], 1'b0}
                  : (jal_i | pc_select_i) ? instr_pc_q + branch_offset_i
                  : instr_pc_q + DATA_WIDTH'(4);
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      instr_d      = instr_q;
      instr_pc_d   = instr_pc_q;
      instret_d    = instret_q;
      misaligned_d = misaligned_q;
      if (state_q == S_FETCH && imem_ready_i) begin
         instr_d    = imem_rdata_i;
         instr_pc_d = pc_q;
         state_d    = S_EXEC;
      end else if (state_q == S_EXEC && ex_done_i) begin
         pc_d      = next_pc;
         instret_d = instret_q + DATA_WIDTH'(1);
         // a misaligned target still retires, then parks the unit in HALT
         if (next_pc[1:0] != 2'b00) begin
            misaligned_d = 1'b1;
            state_d      = S_HALT;
         end else begin
            state_d = halt_req_i ? S_HALT : S_FETCH;
         end
      end
   end
   always_comb begin
      imem_req_o    = state_q == S_FETCH;
      instr_valid_o = state_q == S_EXEC;
      halted_o      = state_q == S_HALT;
   end
   assign imem_addr_o  = pc_q;
   assign instr_o      = instr_q;
   assign instr_pc_o   = instr_pc_q;
   assign link_addr_o  = instr_pc_q + DATA_WIDTH'(4);
   assign instret_o    = instret_q;
   assign misaligned_o = misaligned_q;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed self-checking bench for fetch_pc_unit
module tb_fetch_pc_unit;
   logic        clk = 1'b0, reset = 1'b0;
   logic        imem_req, imem_ready = 1'b0, instr_valid, ex_done = 1'b0, pc_select = 1'b0;
   logic        jal = 1'b0, jalr = 1'b0, halt_req = 1'b0, halted, misaligned;
   logic [31:0] imem_addr, imem_rdata = '0, instr, instr_pc, branch_offset = '0;
   logic [31:0] jalr_target = '0, link_addr, instret;
   int          n_checks = 0, n_fail = 0;

   fetch_pc_unit #(.DATA_WIDTH(32), .RESET_PC(32'h100)) dut (
      .clk_i(clk), .reset_i(reset), .imem_req_o(imem_req), .imem_addr_o(imem_addr),
      .imem_ready_i(imem_ready), .imem_rdata_i(imem_rdata), .instr_o(instr),
      .instr_pc_o(instr_pc), .instr_valid_o(instr_valid), .ex_done_i(ex_done),
      .pc_select_i(pc_select), .branch_offset_i(branch_offset), .jal_i(jal),
      .jalr_i(jalr), .jalr_target_i(jalr_target), .halt_req_i(halt_req),
      .link_addr_o(link_addr), .instret_o(instret), .halted_o(halted),
      .misaligned_o(misaligned)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ex();
      ex_done = 0; pc_select = 0; jal = 0; jalr = 0; halt_req = 0;
      branch_offset = '0; jalr_target = '0;
   endtask

   task automatic do_reset();
      reset = 1; tick(); reset = 0;
   endtask

   task automatic fetch_one(input logic [31:0] word);
      imem_rdata = word; imem_ready = 1; tick(); imem_ready = 0;
   endtask

   task automatic goto(input logic [31:0] addr);
      fetch_one(32'h0000_0067);
      jalr = 1; jalr_target = addr; ex_done = 1; tick(); clear_ex();
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL reset_req got %0b want 1", imem_req); end
      n_checks++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL reset_addr got %h want 00000100", imem_addr); end
      n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", instr_valid); end
      n_checks++; if (instret !== 32'h0) begin n_fail++; $display("FAIL reset_instret got %h want 0", instret); end
      n_checks++; if ({halted, misaligned} !== 2'b00) begin n_fail++; $display("FAIL reset_status got %b want 00", {halted, misaligned}); end
      n_checks++; if ({instr, instr_pc} !== 64'h0) begin n_fail++; $display("FAIL reset_instr got %h/%h want 0/0", instr, instr_pc); end
   endtask

   task automatic test_sequential();
      imem_ready = 1; ex_done = 1; imem_rdata = 32'h0000_0013;
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (imem_addr !== 32'h100 + 32'(4 * i) || imem_req !== 1'b1) begin n_fail++; $display("FAIL seq_fetch%0d got %h/%0b want %h/1", i, imem_addr, imem_req, 32'h100 + 32'(4 * i)); end
         n_checks++; if (instret !== 32'(i)) begin n_fail++; $display("FAIL seq_instret%0d got %0d want %0d", i, instret, i); end
         tick();
         n_checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin n_fail++; $display("FAIL seq_exec%0d got valid %0b req %0b want 1/0", i, instr_valid, imem_req); end
         n_checks++; if (instr_pc !== 32'h100 + 32'(4 * i) || link_addr !== 32'h104 + 32'(4 * i)) begin n_fail++; $display("FAIL seq_link%0d got %h/%h", i, instr_pc, link_addr); end
         if (i < 2) tick();
      end
      imem_ready = 0; ex_done = 0;
      tick();
   endtask

   task automatic test_stall();
      goto(32'h0);
      imem_rdata = 32'hDEAD_BEEF; ex_done = 1; halt_req = 1; pc_select = 1;
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL stall%0d got req %0b addr %h valid %0b want 1/0/0", i, imem_req, imem_addr, instr_valid); end
         tick();
      end
      clear_ex();
      imem_ready = 1; tick(); imem_rdata = 32'h1234_5678;
      n_checks++; if (instr !== 32'hDEAD_BEEF || instr_pc !== 32'h0 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL stall_latch got %h/%h/%0b want deadbeef/0/1", instr, instr_pc, instr_valid); end
      tick(); tick();
      n_checks++; if (instr !== 32'hDEAD_BEEF || instr_valid !== 1'b1 || imem_req !== 1'b0) begin n_fail++; $display("FAIL exec_hold got %h/%0b/%0b want deadbeef/1/0", instr, instr_valid, imem_req); end
      imem_ready = 0; ex_done = 1; tick(); clear_ex();
      n_checks++; if (imem_addr !== 32'h4 || imem_req !== 1'b1) begin n_fail++; $display("FAIL exec_done got %h/%0b want 00000004/1", imem_addr, imem_req); end
   endtask

   task automatic test_branch();
      goto(32'h20); fetch_one(32'h0);
      pc_select = 1; branch_offset = 32'hFFFF_FFF0; ex_done = 1; tick(); clear_ex();
      n_checks++; if (imem_addr !== 32'h10) begin n_fail++; $display("FAIL branch_taken got %h want 00000010", imem_addr); end
      goto(32'h20); fetch_one(32'h0);
      branch_offset = 32'hFFFF_FFF0; ex_done = 1; tick(); clear_ex();
      n_checks++; if (imem_addr !== 32'h24) begin n_fail++; $display("FAIL branch_not_taken got %h want 00000024", imem_addr); end
      goto(32'hFFFF_FFFC); fetch_one(32'h0);
      ex_done = 1; tick(); clear_ex();
      n_checks++; if (imem_addr !== 32'h0 || misaligned !== 1'b0) begin n_fail++; $display("FAIL pc_wrap got %h/%0b want 0/0", imem_addr, misaligned); end
   endtask

   task automatic test_priority();
      goto(32'h8); fetch_one(32'h0);
      jal = 1; jalr = 1; branch_offset = 32'h40; jalr_target = 32'h201; ex_done = 1; tick(); clear_ex();
      n_checks++; if (imem_addr !== 32'h200 || misaligned !== 1'b0 || imem_req !== 1'b1) begin n_fail++; $display("FAIL jalr_wins got %h/%0b want 00000200/0", imem_addr, misaligned); end
      fetch_one(32'h0);
      jal = 1; pc_select = 0; branch_offset = 32'h40; ex_done = 1; tick(); clear_ex();
      n_checks++; if (imem_addr !== 32'h240) begin n_fail++; $display("FAIL jal_target got %h want 00000240", imem_addr); end
   endtask

   task automatic test_misaligned();
      goto(32'h0); fetch_one(32'h0);
      jal = 1; branch_offset = 32'h2; ex_done = 1; tick();
      imem_ready = 1;
      n_checks++; if (misaligned !== 1'b1 || halted !== 1'b1) begin n_fail++; $display("FAIL misalign_flags got %0b/%0b want 1/1", misaligned, halted); end
      n_checks++; if (imem_addr !== 32'h2 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL misalign_pc got %h/%0b/%0b want 2/0/0", imem_addr, imem_req, instr_valid); end
      tick(); tick();
      n_checks++; if (halted !== 1'b1 || imem_req !== 1'b0 || imem_addr !== 32'h2) begin n_fail++; $display("FAIL halt_sticky got %0b/%0b/%h want 1/0/2", halted, imem_req, imem_addr); end
      clear_ex(); imem_ready = 0;
      do_reset();
      n_checks++; if ({misaligned, halted, instr_valid} !== 3'b000 || imem_req !== 1'b1 || imem_addr !== 32'h100 || instret !== 32'h0) begin n_fail++; $display("FAIL misalign_reset got m%0b h%0b req%0b %h instret %0d", misaligned, halted, imem_req, imem_addr, instret); end
   endtask

   task automatic test_halt();
      for (int i = 0; i < 5; i++) begin
         fetch_one(32'h0); ex_done = 1; tick(); clear_ex();
      end
      fetch_one(32'h0);
      n_checks++; if (instret !== 32'd5 || instr_pc !== 32'h114) begin n_fail++; $display("FAIL pre_halt got %0d/%h want 5/00000114", instret, instr_pc); end
      halt_req = 1; ex_done = 1; tick(); clear_ex();
      n_checks++; if (instret !== 32'd6 || halted !== 1'b1 || misaligned !== 1'b0) begin n_fail++; $display("FAIL halt got %0d/%0b/%0b want 6/1/0", instret, halted, misaligned); end
      n_checks++; if (imem_addr !== 32'h118 || imem_req !== 1'b0) begin n_fail++; $display("FAIL halt_pc got %h/%0b want 00000118/0", imem_addr, imem_req); end
   endtask

   task automatic test_reset_in_exec();
      do_reset();
      fetch_one(32'hAAAA_5555);
      ex_done = 1; jal = 1; branch_offset = 32'h80; reset = 1; tick(); reset = 0; clear_ex();
      n_checks++; if (instret !== 32'h0 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL reset_exec got %0d/%h want 0/00000100", instret, imem_addr); end
      n_checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || instr !== 32'h0) begin n_fail++; $display("FAIL reset_exec_state got %0b/%0b/%h want 0/1/0", instr_valid, imem_req, instr); end
      imem_rdata = 32'h5555_AAAA; imem_ready = 1; reset = 1; tick(); reset = 0; imem_ready = 0;
      n_checks++; if (instr !== 32'h0 || instr_valid !== 1'b0 || imem_req !== 1'b1) begin n_fail++; $display("FAIL reset_fetch got %h/%0b/%0b want 0/0/1", instr, instr_valid, imem_req); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_branch();
      test_priority();
      test_misaligned();
      test_halt();
      test_reset_in_exec();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Fetch/PC stage directly upstream of the ALU: holds the program counter, fetches one instruction at a time from instruction memory and presents it to decode/ALU.
- Consumes the ALU's branch decision (PC_select) and the JALR target (ALU out) to compute the next PC.
- Non-pipelined, multi-cycle: one instruction in flight; FSM FETCH -> EXEC -> FETCH, plus a terminal HALT.

Parameters:
- RESET_PC, 32'h00000000, PC loaded on reset.
- `data_width (from parameters.v), 32, width of PC, instruction, offsets and targets.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request; high only in S_FETCH.
- imem_addr  output  32  fetch address; equals pc.
- imem_ready  input  1  imem_rdata valid this cycle (sampled only in S_FETCH).
- imem_rdata  input  32  fetched instruction word.
- instr  output  32  latched instruction for decode.
- instr_pc  output  32  PC of instr.
- instr_valid  output  1  instr/instr_pc valid; high exactly in S_EXEC.
- ex_done  input  1  decode/ALU finished the current instruction (sampled only in S_EXEC).
- pc_select  input  1  ALU branch-taken flag, qualified by ex_done.
- branch_offset  input  32  sign-extended B/J immediate.
- jal  input  1  current instruction is JAL.
- jalr  input  1  current instruction is JALR.
- jalr_target  input  32  ALU out (rs1+imm) for JALR.
- halt_req  input  1  halt after current instruction, qualified by ex_done.
- link_addr  output  32  instr_pc + 4, for rd write of JAL/JALR.
- instret  output  32  retired-instruction count.
- halted  output  1  in S_HALT.
- misaligned  output  1  sticky; next PC had bits [1:0] != 0.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high; all state updates occur on the rising edge of clk.
- Reset values: state=S_FETCH, pc=RESET_PC, instr=0, instr_pc=0, instret=0, halted=0, misaligned=0. Combinational outputs derive from these, so instr_valid=0. imem_req=1 in the first cycle after reset deasserts.
- Reset asserted in any state, including mid-fetch or mid-EXEC, abandons the operation with no retire, no PC update and no outstanding request.
- S_FETCH:
  - imem_req=1, imem_addr=pc.
  - If imem_ready, then on that edge instr<=imem_rdata, instr_pc<=pc, state<=S_EXEC.
  - Otherwise hold; wait indefinitely.
  - ex_done, pc_select and halt_req are ignored in this state.
- S_EXEC:
  - instr_valid=1; instr, instr_pc and link_addr are stable for the whole state.
  - imem_req=0; imem_ready is ignored.
  - Without ex_done, hold indefinitely.
  - On ex_done, next_pc uses priority jalr > jal > pc_select > sequential:
    - jalr: jalr_target & ~32'h1
    - jal: instr_pc + branch_offset
    - pc_select: instr_pc + branch_offset
    - otherwise: instr_pc + 4
  - All additions are modulo 2^32; wrap-around is silent.
  - Also on ex_done: pc<=next_pc and instret<=instret+1 (wraps 0xFFFFFFFF->0).
  - If next_pc[1:0]!=0: misaligned<=1, state<=S_HALT. The instruction still counts as retired and pc holds the misaligned value.
  - Else if halt_req: state<=S_HALT.
  - Else: state<=S_FETCH.
- S_HALT: imem_req=0, instr_valid=0, halted=1. All inputs are ignored; exit only via reset.
- Timing and latency:
  - Minimum 2 cycles per instruction: imem_ready in the first FETCH cycle and ex_done in the first EXEC cycle.
  - next_pc appears on imem_addr in the cycle after ex_done.
- Output timing: link_addr is combinational from instr_pc; halted is combinational from state; misaligned is registered.

Test Plan:
- Reset with RESET_PC=0x100, imem_ready tied 1, ex_done tied 1, no branches -> imem_addr goes 0x100, 0x104, 0x108 on alternate cycles; instret increments every 2 cycles; link_addr=0x104 while instr_pc=0x100.
- imem_ready low for 3 cycles at pc=0x0 -> imem_req held 1 and imem_addr 0x0 throughout; instr_valid stays 0; instr latches rdata on the 4th cycle.
- At instr_pc=0x20: pc_select=1, branch_offset=0xFFFFFFF0 -> next imem_addr=0x10. With pc_select=0 -> 0x24.
- jal=1, jalr=1, branch_offset=0x40, jalr_target=0x201 at instr_pc=0x8 -> next imem_addr=0x200 (jalr wins, bit0 cleared).
- jal with offset 0x2 at instr_pc=0x0 -> misaligned=1, halted=1, pc=0x2, imem_req stays 0. Then assert reset for 1 cycle -> all cleared, fetch from RESET_PC.
- halt_req with ex_done at instret=5 -> instret=6, halted=1. Assert reset during S_EXEC (no ex_done) -> instret=0, no retire counted.
